// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet deframer: parser states,
// one-hot frame status codes, default SOF marker and checksum width helper.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK
  } state_e;

  localparam int unsigned STS_W = 5;

  // One-hot status word: {tmo, line, len, chk, ok}
  localparam logic [STS_W-1:0] STS_NONE = 5'b00000;
  localparam logic [STS_W-1:0] STS_OK   = 5'b00001;
  localparam logic [STS_W-1:0] STS_CHK  = 5'b00010;
  localparam logic [STS_W-1:0] STS_LEN  = 5'b00100;
  localparam logic [STS_W-1:0] STS_LINE = 5'b01000;
  localparam logic [STS_W-1:0] STS_TMO  = 5'b10000;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Checksum is a modular byte sum, so it is as wide as one data word.
  function automatic int unsigned chk_width(input int unsigned data_bits);
    return data_bits;
  endfunction

endpackage

// File: rtl/uart_pkt_out_reg.sv
// One-entry payload output register: holds data/sop/eop stable while valid
// and not ready; accepts a new load in the same cycle as a handshake.
module uart_pkt_out_reg #(
  parameter int unsigned P_DATA_BITS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [P_DATA_BITS-1:0] data_i,
  input  logic                   sop_i,
  input  logic                   eop_i,
  input  logic                   ready_i,
  output logic                   can_load_o,
  output logic                   valid_o,
  output logic [P_DATA_BITS-1:0] data_o,
  output logic                   sop_o,
  output logic                   eop_o
);

  logic                   valid_q, valid_d;
  logic [P_DATA_BITS-1:0] data_q, data_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;

  assign can_load_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sop_d   = sop_i;
      eop_d   = eop_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

endmodule

// File: rtl/uart_pkt_deframer.sv
// UART packet deframer: parses SOF, LEN, payload[LEN], CHK from the RX FIFO.
// Optional inter-byte timeout enabled by `define UART_PKT_DEFRAMER_TIMEOUT_EN.
module uart_pkt_deframer
  import uart_pkt_pkg::*;
#(
  parameter int unsigned                P_DATA_BITS   = 8,
  parameter logic [P_DATA_BITS-1:0]     P_SOF_BYTE    = P_DATA_BITS'(SOF_DEFAULT),
  parameter int unsigned                P_MAX_LEN     = 64,
  parameter int unsigned                P_TIMEOUT_CYC = 100000
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic [P_DATA_BITS-1:0] i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_rx_parity_err,
  input  logic                   i_rx_framing_err,
  output logic                   o_rx_read_en,
  output logic [P_DATA_BITS-1:0] o_pld_data,
  output logic                   o_pld_valid,
  input  logic                   i_pld_ready,
  output logic                   o_pld_sop,
  output logic                   o_pld_eop,
  output logic                   o_frm_done,
  output logic                   o_frm_ok,
  output logic                   o_err_chk,
  output logic                   o_err_len,
  output logic                   o_err_line,
  output logic                   o_err_tmo,
  output logic [15:0]            o_frm_cnt
);

  localparam int unsigned            CHK_W     = chk_width(P_DATA_BITS);
  localparam logic [P_DATA_BITS-1:0] MAX_LEN_W = P_DATA_BITS'(P_MAX_LEN);
  localparam logic [P_DATA_BITS-1:0] ONE_W     = P_DATA_BITS'(1);

  state_e                 state_q, state_d;
  logic [CHK_W-1:0]       sum_q, sum_d;
  logic [P_DATA_BITS-1:0] rem_q, rem_d;
  logic                   first_q, first_d;
  logic [STS_W-1:0]       sts_q, sts_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   rd_en;
  logic                   rx_err;
  logic                   can_load;
  logic                   stall;
  logic                   tmo_hit;
  logic                   ld;
  logic                   ld_sop;
  logic                   ld_eop;

  assign rx_err = i_rx_parity_err | i_rx_framing_err;

  // Pop decision kept apart from the FSM so the timeout path does not loop back into it.
  always_comb begin
    rd_en = 1'b0;
    if (!i_sys_rst) begin
      if (state_q == ST_PAYLOAD) rd_en = i_rx_valid && can_load;
      else                       rd_en = i_rx_valid;
    end
  end

  assign stall        = (state_q == ST_PAYLOAD) && i_rx_valid && !can_load;
  assign o_rx_read_en = rd_en;

`ifdef UART_PKT_DEFRAMER_TIMEOUT_EN
  localparam int unsigned TMO_W = (P_TIMEOUT_CYC > 1) ? $clog2(P_TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (state_q != ST_IDLE) && !rd_en && !stall &&
                   (tmo_q == TMO_W'(P_TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_IDLE || rd_en || tmo_hit) tmo_d = '0;
    else if (!stall)                            tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) tmo_q <= '0;
    else           tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (P_TIMEOUT_CYC == 0) | stall;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    first_d = first_q;
    sts_d   = STS_NONE;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    ld_sop  = 1'b0;
    ld_eop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_en && !rx_err && i_rx_data == P_SOF_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rd_en) begin
          if (rx_err) begin
            sts_d   = STS_LINE;
            state_d = ST_IDLE;
          end else if (i_rx_data > MAX_LEN_W) begin
            sts_d   = STS_LEN;
            state_d = ST_IDLE;
          end else if (i_rx_data == '0) begin
            sum_d   = '0;
            state_d = ST_CHK;
          end else begin
            rem_d   = i_rx_data;
            sum_d   = i_rx_data;
            first_d = 1'b1;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rd_en) begin
          if (rx_err) begin
            sts_d   = STS_LINE;
            state_d = ST_IDLE;
          end else begin
            ld      = 1'b1;
            ld_sop  = first_q;
            ld_eop  = (rem_q == ONE_W);
            first_d = 1'b0;
            sum_d   = sum_q + i_rx_data;
            rem_d   = rem_q - ONE_W;
            if (rem_q == ONE_W) state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (rd_en) begin
          if (rx_err) begin
            sts_d = STS_LINE;
          end else if (i_rx_data == sum_q) begin
            sts_d = STS_OK;
            cnt_d = cnt_q + 16'd1;
          end else begin
            sts_d = STS_CHK;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      sts_d   = STS_TMO;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      sts_q   <= STS_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      sts_q   <= sts_d;
      cnt_q   <= cnt_d;
    end
  end

  uart_pkt_out_reg #(
    .P_DATA_BITS(P_DATA_BITS)
  ) u_out_reg (
    .clk_i      (i_sys_clk),
    .rst_i      (i_sys_rst),
    .load_i     (ld),
    .data_i     (i_rx_data),
    .sop_i      (ld_sop),
    .eop_i      (ld_eop),
    .ready_i    (i_pld_ready),
    .can_load_o (can_load),
    .valid_o    (o_pld_valid),
    .data_o     (o_pld_data),
    .sop_o      (o_pld_sop),
    .eop_o      (o_pld_eop)
  );

  assign o_frm_done = |sts_q;
  assign o_frm_ok   = |(sts_q & STS_OK);
  assign o_err_chk  = |(sts_q & STS_CHK);
  assign o_err_len  = |(sts_q & STS_LEN);
  assign o_err_line = |(sts_q & STS_LINE);
  assign o_err_tmo  = |(sts_q & STS_TMO);
  assign o_frm_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed bench for uart_pkt_deframer. Checksum = LEN + sum(payload) mod 256.
// Timeout case is exercised when UART_PKT_DEFRAMER_TIMEOUT_EN is defined.
module tb_uart_pkt_deframer;

  localparam logic [4:0] S_OK   = 5'b00001;
  localparam logic [4:0] S_CHK  = 5'b00010;
  localparam logic [4:0] S_LEN  = 5'b00100;
  localparam logic [4:0] S_LINE = 5'b01000;
  localparam logic [4:0] S_TMO  = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_par = 1'b0;
  logic        rx_fr = 1'b0;
  logic        rd_en;
  logic [7:0]  pld_data;
  logic        pld_valid;
  logic        pld_ready = 1'b1;
  logic        pld_sop, pld_eop;
  logic        frm_done, frm_ok, err_chk, err_len, err_line, err_tmo;
  logic [15:0] frm_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [9:0]  fifo[$];    // {framing, parity, data}
  logic [9:0]  beats[$];   // {sop, eop, data}
  logic [4:0]  stss[$];
  int unsigned sts_cyc[$];
  int unsigned cyc = 0;
  int unsigned last_pop = 0;
  logic        stall_en = 1'b0;
  int unsigned stall_cnt = 0;

  always #5 clk = ~clk;

  uart_pkt_deframer #(
    .P_DATA_BITS  (8),
    .P_SOF_BYTE   (8'hA5),
    .P_MAX_LEN    (64),
    .P_TIMEOUT_CYC(50)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .i_rx_parity_err (rx_par),
    .i_rx_framing_err(rx_fr),
    .o_rx_read_en    (rd_en),
    .o_pld_data      (pld_data),
    .o_pld_valid     (pld_valid),
    .i_pld_ready     (pld_ready),
    .o_pld_sop       (pld_sop),
    .o_pld_eop       (pld_eop),
    .o_frm_done      (frm_done),
    .o_frm_ok        (frm_ok),
    .o_err_chk       (err_chk),
    .o_err_len       (err_len),
    .o_err_line      (err_line),
    .o_err_tmo       (err_tmo),
    .o_frm_cnt       (frm_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FWFT FIFO model: pop on the edge where read enable was high, present head after it.
  always @(posedge clk) begin
    logic popped;
    popped = rd_en;
    cyc++;
    if (popped && fifo.size() > 0) begin
      void'(fifo.pop_front());
      last_pop = cyc;
    end
    #1;
    rx_valid = (fifo.size() > 0);
    rx_data  = rx_valid ? fifo[0][7:0] : '0;
    rx_par   = rx_valid ? fifo[0][8] : 1'b0;
    rx_fr    = rx_valid ? fifo[0][9] : 1'b0;
    if (stall_en && pld_valid && pld_data == 8'h22 && stall_cnt < 10) begin
      pld_ready = 1'b0;
      stall_cnt++;
    end else begin
      pld_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pld_valid && pld_ready) beats.push_back({pld_sop, pld_eop, pld_data});
      if (frm_done) begin
        stss.push_back({err_tmo, err_line, err_len, err_chk, frm_ok});
        sts_cyc.push_back(cyc);
      end
      if (stall_en && pld_valid && !pld_ready) begin
        check("hold_data", {24'd0, pld_data}, 32'h22);
        check("hold_rd_en", {31'd0, rd_en}, 32'd0);
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back({2'b00, b});
  endtask

  task automatic push_err(input logic [7:0] b, input logic par, input logic fr);
    fifo.push_back({fr, par, b});
  endtask

  task automatic clear_logs();
    beats.delete();
    stss.delete();
    sts_cyc.delete();
  endtask

  task automatic wait_sts(input int unsigned n);
    int unsigned k = 0;
    while (stss.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("sts_count", stss.size(), n);
    repeat (3) @(negedge clk);
  endtask

  task automatic exp_beat(input string tag, input logic [9:0] e);
    logic [9:0] g;
    g = '1;
    if (beats.size() > 0) g = beats.pop_front();
    check(tag, {22'd0, g}, {22'd0, e});
  endtask

  task automatic exp_sts(input string tag, input logic [4:0] e);
    logic [4:0] g;
    g = '1;
    if (stss.size() > 0) g = stss.pop_front();
    check(tag, {27'd0, g}, {27'd0, e});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, pld_valid}, 32'd0);
    check("rst_done", {31'd0, frm_done}, 32'd0);
    check("rst_cnt", {16'd0, frm_cnt}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good frame
    clear_logs();
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
    wait_sts(1);
    exp_beat("good_b0", {2'b10, 8'h11});
    exp_beat("good_b1", {2'b00, 8'h22});
    exp_beat("good_b2", {2'b01, 8'h33});
    check("good_nbeats", beats.size(), 0);
    exp_sts("good_sts", S_OK);
    check("good_cnt", {16'd0, frm_cnt}, 32'd1);

    // Checksum mismatch (payload-only sum 66 is not the frame checksum)
    clear_logs();
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h66);
    wait_sts(1);
    exp_beat("chk_b0", {2'b10, 8'h11});
    exp_beat("chk_b1", {2'b00, 8'h22});
    exp_beat("chk_b2", {2'b01, 8'h33});
    exp_sts("chk_sts", S_CHK);
    check("chk_cnt", {16'd0, frm_cnt}, 32'd1);

    // Backpressure on beat 22
    clear_logs();
    stall_cnt = 0;
    stall_en  = 1'b1;
    push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h69);
    wait_sts(1);
    stall_en = 1'b0;
    check("bp_stall_cycles", stall_cnt, 10);
    exp_beat("bp_b0", {2'b10, 8'h11});
    exp_beat("bp_b1", {2'b00, 8'h22});
    exp_beat("bp_b2", {2'b01, 8'h33});
    check("bp_nbeats", beats.size(), 0);
    exp_sts("bp_sts", S_OK);
    check("bp_cnt", {16'd0, frm_cnt}, 32'd2);

    // Garbage, errored SOF, over-length frame, then empty frame
    clear_logs();
    push(8'h00); push(8'hFF); push_err(8'hA5, 1'b0, 1'b1); push(8'h03);
    push(8'hA5); push(8'h41);
    push(8'hA5); push(8'h00); push(8'h00);
    wait_sts(2);
    exp_sts("len_sts", S_LEN);
    exp_sts("empty_sts", S_OK);
    check("len_nbeats", beats.size(), 0);
    check("len_cnt", {16'd0, frm_cnt}, 32'd3);

    // Parity error on second payload byte, then recovery
    clear_logs();
    push(8'hA5); push(8'h03); push(8'h11); push_err(8'h22, 1'b1, 1'b0); push(8'h33); push(8'h69);
    push(8'hA5); push(8'h01); push(8'h5A); push(8'h5B);
    wait_sts(2);
    exp_sts("line_sts", S_LINE);
    exp_sts("rec_sts", S_OK);
    exp_beat("line_b0", {2'b10, 8'h11});
    exp_beat("rec_b0", {2'b11, 8'h5A});
    check("line_nbeats", beats.size(), 0);
    check("line_cnt", {16'd0, frm_cnt}, 32'd4);

    // Reset mid-payload
    clear_logs();
    push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
    for (int unsigned i = 0; i < 50 && fifo.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(8'h77);
    repeat (2) @(negedge clk);
    check("mrst_valid", {31'd0, pld_valid}, 32'd0);
    check("mrst_done", {31'd0, frm_done}, 32'd0);
    check("mrst_cnt", {16'd0, frm_cnt}, 32'd0);
    check("mrst_rd_en", {31'd0, rd_en}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_no_sts", stss.size(), 0);
    clear_logs();
    push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h32);
    wait_sts(1);
    exp_beat("post_b0", {2'b10, 8'h10});
    exp_beat("post_b1", {2'b01, 8'h20});
    exp_sts("post_sts", S_OK);
    check("post_cnt", {16'd0, frm_cnt}, 32'd1);

    // Inter-byte silence inside a frame
    clear_logs();
    push(8'hA5); push(8'h02); push(8'h11);
`ifdef UART_PKT_DEFRAMER_TIMEOUT_EN
    wait_sts(1);
    check("tmo_delay", (sts_cyc.size() > 0) ? sts_cyc[0] - last_pop : 0, 50);
    exp_sts("tmo_sts", S_TMO);
    exp_beat("tmo_b0", {2'b10, 8'h11});
    check("tmo_cnt", {16'd0, frm_cnt}, 32'd1);
`else
    repeat (70) @(negedge clk);
    check("notmo_nsts", stss.size(), 0);
    check("notmo_flag", {31'd0, err_tmo}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
